// File: rtl/vga_stream_out.sv
// Programmable-timing VGA raster generator fed by a valid/ready pixel stream.
// A small FIFO buffers the stream; SOF words lock the stream to raster origin.
module vga_stream_out #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CBITS      = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SYNC_POL   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3*CBITS-1:0] pix_data,
  input  logic               pix_sof,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [CBITS-1:0]   vga_r,
  output logic [CBITS-1:0]   vga_g,
  output logic [CBITS-1:0]   vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [11:0]        sx,
  output logic [11:0]        sy,
  output logic               frame_start,
  output logic               underflow,
  input  logic               clr_underflow
);

  localparam int unsigned HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned DW     = 3 * CBITS;
  localparam int unsigned EW     = DW + 1;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam logic        IDLE_LVL = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, RESYNC, RUN} state_t;

  state_t          state, state_nxt;
  logic [11:0]     cx, cy;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, push, pop, flush;
  logic [EW-1:0]   head;
  logic            head_sof;
  logic [DW-1:0]   head_data;
  logic            active, at_origin, at_end, hs_act, vs_act;
  logic            err, show;

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pix_ready = !full && (state != IDLE);
  assign push      = pix_valid && pix_ready && !flush;
  assign head      = mem[rd_ptr];
  assign head_sof  = head[EW-1];
  assign head_data = head[DW-1:0];

  assign active    = (cx < 12'(H_ACTIVE)) && (cy < 12'(V_ACTIVE));
  assign at_origin = (cx == 12'd0) && (cy == 12'd0);
  assign at_end    = (cx == 12'(HT - 1)) && (cy == 12'(VT - 1));
  assign hs_act    = (cx >= 12'(HS_BEG)) && (cx < 12'(HS_END));
  assign vs_act    = (cy >= 12'(VS_BEG)) && (cy < 12'(VS_END));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Stream alignment: drop junk until SOF, then consume one word per active pixel.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    err       = 1'b0;
    show      = 1'b0;
    flush     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      flush     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = RESYNC;
          flush     = 1'b1;
        end
        RESYNC: begin
          if (!empty && !head_sof) pop = 1'b1;
          if (at_end && !empty && head_sof) state_nxt = RUN;
        end
        RUN: begin
          if (active) begin
            if (empty) begin
              err       = 1'b1;
              state_nxt = RESYNC;
            end else if (head_sof != at_origin) begin
              // A misplaced SOF stays at the head so the next frame can lock on it.
              err       = 1'b1;
              state_nxt = RESYNC;
              pop       = !head_sof;
            end else begin
              pop  = 1'b1;
              show = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Raster counters, held at origin while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx <= '0;
      cy <= '0;
    end else if (!enable || state == IDLE) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == 12'(HT - 1)) begin
      cx <= '0;
      cy <= (cy == 12'(VT - 1)) ? 12'd0 : cy + 12'd1;
    end else begin
      cx <= cx + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_sof, pix_data};
  end

  // Output stage, one clock behind cx/cy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      hsync       <= IDLE_LVL;
      vsync       <= IDLE_LVL;
      de          <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      frame_start <= 1'b0;
    end else if (!enable || state == IDLE) begin
      {vga_r, vga_g, vga_b} <= '0;
      hsync       <= IDLE_LVL;
      vsync       <= IDLE_LVL;
      de          <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= show ? head_data : '0;
      hsync       <= hs_act ^ IDLE_LVL;
      vsync       <= vs_act ^ IDLE_LVL;
      de          <= active;
      sx          <= cx;
      sy          <= cy;
      frame_start <= at_origin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               underflow <= 1'b0;
    else if (err)           underflow <= 1'b1;
    else if (clr_underflow) underflow <= 1'b0;
  end

endmodule

// File: tb/tb_vga_stream_out.sv
// Randomised bench for vga_stream_out with a frame-position/queue reference model.
module tb_vga_stream_out;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned CB = 2, DEP = 4, POL = 0;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned DW = 3 * CB;

  logic          clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_sof = 1'b0, pix_valid = 1'b0, clr_underflow = 1'b0;
  logic          pix_ready, hsync, vsync, de, frame_start, underflow;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic [11:0]   sx, sy;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CBITS(CB), .FIFO_DEPTH(DEP), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .sx(sx), .sy(sy),
    .frame_start(frame_start), .underflow(underflow), .clr_underflow(clr_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 hunting for SOF, 2 locked; pos = linear raster index.
  int            mode, pos;
  logic [DW:0]   mq[$];
  logic [DW:0]   src[$];
  logic          m_uf;
  logic [DW-1:0] e_rgb;
  logic          e_hs, e_vs, e_de, e_fs, e_ready;
  logic [11:0]   e_sx, e_sy;
  int            n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_outs();
    e_rgb = '0; e_hs = 1'(POL == 0); e_vs = 1'(POL == 0);
    e_de = 1'b0; e_fs = 1'b0; e_sx = '0; e_sy = '0;
  endtask

  task automatic model_reset();
    mode = 0; pos = 0; mq.delete(); m_uf = 1'b0; e_ready = 1'b0;
    idle_outs();
  endtask

  task automatic model_step(output bit acc);
    bit ready, err, act;
    int cx, cy;
    logic [DW:0] w;
    ready = (mq.size() < DEP) && (mode != 0);
    acc   = ready && pix_valid && enable;
    err   = 1'b0;
    if (!enable) begin
      idle_outs(); mq.delete(); mode = 0; pos = 0;
    end else if (mode == 0) begin
      idle_outs(); mode = 1;
    end else begin
      cx = pos % HT; cy = pos / HT;
      act  = (cx < HA) && (cy < VA);
      e_sx = 12'(cx); e_sy = 12'(cy); e_de = act; e_fs = (pos == 0);
      e_hs = ((cx >= HA + HF) && (cx < HA + HF + HS)) ? 1'(POL != 0) : 1'(POL == 0);
      e_vs = ((cy >= VA + VF) && (cy < VA + VF + VS)) ? 1'(POL != 0) : 1'(POL == 0);
      e_rgb = '0;
      if (mode == 1) begin
        if (mq.size() > 0 && !mq[0][DW]) void'(mq.pop_front());
        else if (pos == FT - 1 && mq.size() > 0) mode = 2;
      end else if (act) begin
        if (mq.size() == 0) begin
          err = 1'b1; mode = 1;
        end else begin
          w = mq[0];
          if (w[DW] != (pos == 0)) begin
            err = 1'b1; mode = 1;
            if (!w[DW]) void'(mq.pop_front());
          end else begin
            e_rgb = w[DW-1:0];
            void'(mq.pop_front());
          end
        end
      end
      pos = (pos + 1) % FT;
      if (acc) mq.push_back({pix_sof, pix_data});
    end
    if (err) m_uf = 1'b1;
    else if (clr_underflow) m_uf = 1'b0;
    e_ready = (mq.size() < DEP) && (mode != 0);
  endtask

  task automatic check_all();
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("de", 32'(de), 32'(e_de));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("sx", 32'(sx), 32'(e_sx));
    chk("sy", 32'(sy), 32'(e_sy));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("pix_ready", 32'(pix_ready), 32'(e_ready));
  endtask

  task automatic cycle(input int pct);
    bit acc;
    pix_valid = (src.size() > 0) && ($urandom_range(99) < 32'(pct));
    if (src.size() > 0) {pix_sof, pix_data} = src[0];
    else {pix_sof, pix_data} = '0;
    @(posedge clk);
    model_step(acc);
    if (acc) void'(src.pop_front());
    #1 check_all();
  endtask

  task automatic run(input int n, input int pct);
    repeat (n) cycle(pct);
  endtask

  task automatic add_frame(input bit counting);
    logic [DW:0] w;
    for (int i = 0; i < int'(HA * VA); i++) begin
      w = {1'(i == 0), counting ? DW'(i) : DW'($urandom)};
      src.push_back(w);
    end
  endtask

  task automatic pulse_clr();
    clr_underflow = 1'b1;
    cycle(100);
    clr_underflow = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1 check_all();
    rst = 1'b1;
    run(3, 0);

    // Free-running raster with no stream.
    enable = 1'b1;
    run(2 * FT + 5, 0);

    // Aligned counting pattern at full rate.
    repeat (5) add_frame(1'b1);
    run(5 * FT, 100);

    // Random source rate, frequent backpressure and possible starvation.
    repeat (6) add_frame(1'b0);
    run(6 * FT, 70);
    pulse_clr();

    // Starve mid-frame, then supply fresh frames and clear the flag.
    src.delete();
    repeat (2) add_frame(1'b0);
    run(FT + FT / 2, 100);
    src.delete();
    run(FT, 100);
    repeat (3) add_frame(1'b0);
    run(4 * FT, 100);
    pulse_clr();

    // Leading junk words ahead of the first SOF.
    enable = 1'b0;
    run(2, 100);
    enable = 1'b1;
    src.delete();
    for (int i = 0; i < 5; i++) src.push_back({1'b0, DW'($urandom)});
    repeat (3) add_frame(1'b0);
    run(4 * FT, 100);

    // Drop enable mid-line, then resume.
    run(FT / 2 + 3, 100);
    enable = 1'b0;
    run(3, 100);
    enable = 1'b1;
    run(2 * FT, 100);

    // Asynchronous reset mid-frame while the FIFO holds data.
    repeat (2) add_frame(1'b0);
    run(FT / 3, 100);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b1;
    run(3 * FT, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
